// File: rtl/rca_config.sv
// Shared RCA configuration: writeback FSM states plus the core-wide XLEN and instruction ID type.
package rca_config;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ID_W = 4;

    typedef logic [ID_W-1:0] id_t;

    typedef enum logic [1:0] {
        WB_IDLE    = 2'd0,
        WB_COLLECT = 2'd1,
        WB_PRESENT = 2'd2
    } rca_wb_state_t;

endpackage

// File: rtl/rca_writeback.sv
// RCA completion stage: pairs the head instruction ID with grid result words and presents
// exactly one completion per instruction to the core writeback port.
module rca_writeback
    import rca_config::*;
#(
    parameter int unsigned DATA_W = XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_populated,
    input  id_t               wb_id,
    input  logic              wb_fb_instr,
    output logic              wb_committing,
    input  logic              clear_fifos,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              res_pop,
    input  logic              loop_done,
    output logic              done,
    output id_t               id,
    output logic [DATA_W-1:0] rd,
    input  logic              ack
);

    rca_wb_state_t     state_q;
    id_t               id_q;
    logic              fb_q;
    logic [DATA_W-1:0] rd_q;
    logic              done_q;
    id_t               id_out_q;
    logic [DATA_W-1:0] rd_out_q;

    // clear_fifos never alters state; it is only checked for protocol misuse.
    logic unused_clear_fifos;
    assign unused_clear_fifos = clear_fifos;

    assign res_pop       = (state_q == WB_COLLECT) && res_valid;
    assign wb_committing = (state_q == WB_PRESENT) && ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= WB_IDLE;
            id_q     <= '0;
            fb_q     <= 1'b0;
            rd_q     <= '0;
            done_q   <= 1'b0;
            id_out_q <= '0;
            rd_out_q <= '0;
        end else begin
            case (state_q)
                WB_IDLE: begin
                    if (fifo_populated) begin
                        id_q    <= wb_id;
                        fb_q    <= wb_fb_instr;
                        rd_q    <= '0;
                        state_q <= WB_COLLECT;
                    end
                end
                WB_COLLECT: begin
                    if (res_pop) begin
                        rd_q <= res_data;
                    end
                    // Feedback loops finish on loop_done; a word popped in that cycle wins.
                    if (fb_q ? loop_done : res_valid) begin
                        state_q  <= WB_PRESENT;
                        done_q   <= 1'b1;
                        id_out_q <= id_q;
                        rd_out_q <= res_pop ? res_data : rd_q;
                    end
                end
                WB_PRESENT: begin
                    if (ack) begin
                        state_q <= WB_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= WB_IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign done = done_q;
    assign id   = id_out_q;
    assign rd   = rd_out_q;

    a_done_stable_until_ack: assert property (@(posedge clk)
        (done && !ack && !rst) |=> (done && $stable(id) && $stable(rd)));

    a_commit_implies_done: assert property (@(posedge clk)
        wb_committing |-> done);

    a_clear_only_in_idle: assert property (@(posedge clk)
        (clear_fifos && !rst) |-> (state_q == WB_IDLE));

endmodule

// File: tb/tb_rca_writeback.sv
// Directed bench for rca_writeback: emulates the controller ID FIFO and grid output FIFO and
// checks every presented completion against a queue of expected (id, rd) pairs.
module tb_rca_writeback;
    import rca_config::*;

    localparam int unsigned DW = XLEN;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_populated;
    id_t           wb_id;
    logic          wb_fb_instr;
    logic          wb_committing;
    logic          clear_fifos;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic          res_pop;
    logic          loop_done;
    logic          done;
    id_t           id;
    logic [DW-1:0] rd;
    logic          ack;

    always #5 clk = ~clk;

    rca_writeback #(.DATA_W(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_populated(fifo_populated),
        .wb_id         (wb_id),
        .wb_fb_instr   (wb_fb_instr),
        .wb_committing (wb_committing),
        .clear_fifos   (clear_fifos),
        .res_valid     (res_valid),
        .res_data      (res_data),
        .res_pop       (res_pop),
        .loop_done     (loop_done),
        .done          (done),
        .id            (id),
        .rd            (rd),
        .ack           (ack)
    );

    typedef struct {
        id_t           id;
        logic [DW-1:0] rd;
    } exp_t;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            pop_cnt  = 0;
    bit            last_pop;
    bit            last_commit;
    id_t           idq[$];
    bit            fbq[$];
    logic [DW-1:0] gq[$];
    exp_t          exp_q[$];
    int            commit_cyc[$];

    function automatic void check(string name, longint unsigned act, longint unsigned req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Single compare process: every cycle, mid-way between active edges.
    always @(negedge clk) begin
        last_pop    = 1'b0;
        last_commit = 1'b0;
        if (!rst) begin
            last_pop    = res_pop;
            last_commit = wb_committing;
            if (res_pop) pop_cnt++;
            check("commit_rule", wb_committing, done && ack);
            if (done) begin
                check("pop_while_done", res_pop, 0);
                if (exp_q.size() == 0) begin
                    check("completion_expected", exp_q.size(), 1);
                end else begin
                    check("id", id, exp_q[0].id);
                    check("rd", rd, exp_q[0].rd);
                    if (ack) begin
                        void'(exp_q.pop_front());
                        commit_cyc.push_back(cyc);
                    end
                end
            end
        end
    end

    task automatic drive_env();
        fifo_populated = (idq.size() != 0);
        wb_id          = (idq.size() != 0) ? idq[0] : '0;
        wb_fb_instr    = (fbq.size() != 0) ? fbq[0] : 1'b0;
        res_valid      = (gq.size() != 0);
        res_data       = (gq.size() != 0) ? gq[0] : '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (last_commit && idq.size() != 0) begin
            void'(idq.pop_front());
            void'(fbq.pop_front());
        end
        if (last_pop && gq.size() != 0) void'(gq.pop_front());
        drive_env();
    endtask

    task automatic wait_done(input string name, output int at);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done) seen = 1'b1;
            else step();
        end
        at = cyc;
        if (!seen) check({name, "_timeout"}, done, 1);
    endtask

    task automatic push_id(input id_t i, input bit fb);
        idq.push_back(i);
        fbq.push_back(fb);
    endtask

    task automatic push_exp(input id_t i, input logic [DW-1:0] r);
        exp_t e;
        e.id = i;
        e.rd = r;
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int t;
        int p0;
        int c0;

        rst         = 1'b1;
        clear_fifos = 1'b0;
        loop_done   = 1'b0;
        ack         = 1'b0;
        drive_env();
        step();
        step();
        check("reset_done", done, 0);
        check("reset_id", id, 0);
        check("reset_rd", rd, 0);
        check("reset_res_pop", res_pop, 0);
        check("reset_commit", wb_committing, 0);
        rst = 1'b0;
        step();

        // Idle with a waiting grid word and a clear_fifos pulse: nothing popped.
        gq.push_back(32'hDEAD_BEEF);
        drive_env();
        clear_fifos = 1'b1;
        step();
        clear_fifos = 1'b0;
        step();
        step();
        check("idle_no_pop", pop_cnt, 0);
        check("idle_res_pop", res_pop, 0);
        check("idle_done", done, 0);

        // Non-feedback single instruction, result already waiting.
        ack = 1'b1;
        p0  = pop_cnt;
        push_exp(4'd5, 32'hDEAD_BEEF);
        push_id(4'd5, 1'b0);
        drive_env();
        t0 = cyc;
        wait_done("nf", t);
        check("nf_latency", t - t0, 2);
        check("nf_id_literal", id, 5);
        check("nf_rd_literal", rd, 32'hDEAD_BEEF);
        step();
        check("nf_done_one_cycle", done, 0);
        check("nf_pops", pop_cnt - p0, 1);
        check("nf_commits", commit_cyc.size(), 1);
        step();

        // Feedback: words 1,2,3 on consecutive cycles, loop_done with word 3.
        p0 = pop_cnt;
        push_exp(4'd2, 32'd3);
        push_id(4'd2, 1'b1);
        drive_env();
        step();
        gq.push_back(32'd1);
        drive_env();
        step();
        gq.push_back(32'd2);
        drive_env();
        step();
        gq.push_back(32'd3);
        loop_done = 1'b1;
        drive_env();
        step();
        loop_done = 1'b0;
        wait_done("fb", t);
        check("fb_rd_literal", rd, 3);
        step();
        check("fb_pops", pop_cnt - p0, 3);
        step();

        // Feedback with no result words at all.
        p0 = pop_cnt;
        push_exp(4'd4, 32'd0);
        push_id(4'd4, 1'b1);
        drive_env();
        repeat (4) step();
        loop_done = 1'b1;
        step();
        loop_done = 1'b0;
        wait_done("fb_empty", t);
        check("fb_empty_rd", rd, 0);
        step();
        check("fb_empty_pops", pop_cnt - p0, 0);
        step();

        // Backpressure: ack low for 10 presented cycles.
        ack = 1'b0;
        push_exp(4'd6, 32'h1234_5678);
        push_id(4'd6, 1'b0);
        gq.push_back(32'h1234_5678);
        drive_env();
        wait_done("bp", t);
        c0 = commit_cyc.size();
        p0 = pop_cnt;
        for (int i = 0; i < 10; i++) begin
            check("bp_done_held", done, 1);
            step();
        end
        ack = 1'b1;
        check("bp_done_at_ack", done, 1);
        step();
        check("bp_done_after_ack", done, 0);
        check("bp_commits", commit_cyc.size() - c0, 1);
        check("bp_no_pops", pop_cnt - p0, 0);
        step();

        // Back-to-back: IDs 7 and 8 queued with results 0xA and 0xB.
        c0 = commit_cyc.size();
        push_exp(4'd7, 32'hA);
        push_exp(4'd8, 32'hB);
        push_id(4'd7, 1'b0);
        push_id(4'd8, 1'b0);
        gq.push_back(32'hA);
        gq.push_back(32'hB);
        drive_env();
        for (int i = 0; i < 30 && commit_cyc.size() < c0 + 2; i++) step();
        check("b2b_count", commit_cyc.size() - c0, 2);
        if (commit_cyc.size() >= c0 + 2) begin
            check("b2b_spacing", commit_cyc[c0 + 1] - commit_cyc[c0], 3);
        end
        step();

        // Reset while presenting.
        ack = 1'b0;
        push_exp(4'd9, 32'h55);
        push_id(4'd9, 1'b0);
        gq.push_back(32'h55);
        drive_env();
        wait_done("rst_mid", t);
        rst = 1'b1;
        ack = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        idq.delete();
        fbq.delete();
        gq.delete();
        drive_env();
        check("rst_mid_done", done, 0);
        check("rst_mid_commit", wb_committing, 0);
        check("rst_mid_id", id, 0);
        check("rst_mid_rd", rd, 0);

        // Back in idle: a waiting word is not popped, a fresh ID completes in 2 cycles.
        gq.push_back(32'h77);
        drive_env();
        p0 = pop_cnt;
        step();
        step();
        check("post_rst_idle_no_pop", pop_cnt - p0, 0);
        push_exp(4'd10, 32'h77);
        push_id(4'd10, 1'b0);
        drive_env();
        t0 = cyc;
        wait_done("post_rst", t);
        check("post_rst_latency", t - t0, 2);
        step();
        step();
        check("all_completions_seen", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rca_writeback.md
# rca_writeback

Completion stage directly downstream of the RCA grid controller. Pairs the oldest in-flight RCA instruction ID (head of the controller's ID FIFO) with result words leaving the grid output FIFO and presents one completion per instruction to the core writeback interface. On each accepted completion it pulses `wb_committing` back to the controller to pop the ID FIFO. Non-feedback instructions complete on their single result word. Feedback instructions absorb result words until the grid signals loop completion, then write back the last word absorbed.

## Interface
Parameters:
- `DATA_W`, default `XLEN`: result word width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `fifo_populated`  in  1  controller ID FIFO non-empty; `wb_id`/`wb_fb_instr` valid.
- `wb_id`  in  `$bits(id_t)`  ID at head of controller FIFO.
- `wb_fb_instr`  in  1  head instruction is a feedback-use instruction.
- `wb_committing`  out  1  one-cycle pulse; pops controller ID FIFO.
- `clear_fifos`  in  1  controller switching RCA; discard staged grid data.
- `res_valid`  in  1  grid output FIFO has a word.
- `res_data`  in  `DATA_W`  grid output FIFO head word.
- `res_pop`  out  1  consume `res_data` this cycle.
- `loop_done`  in  1  one-cycle pulse; active feedback loop has finished.
- `done`  out  1  completion presented to core.
- `id`  out  `$bits(id_t)`  ID of presented completion.
- `rd`  out  `DATA_W`  result value of presented completion.
- `ack`  in  1  core accepts the completion while `done`=1.

## Operation
FSM with three states: `WB_IDLE`, `WB_COLLECT`, `WB_PRESENT`.
- `WB_IDLE`: entered from reset. If `fifo_populated`, latch `wb_id` into `id_r` and `wb_fb_instr` into `fb_r`, then go to `WB_COLLECT`.
- `WB_COLLECT`, non-feedback (`fb_r`=0):
  - `res_pop` = `res_valid`.
  - On a pop, capture `res_data` into `rd_r` and go to `WB_PRESENT`.
- `WB_COLLECT`, feedback (`fb_r`=1):
  - `res_pop` = `res_valid` every cycle. Every popped word overwrites `rd_r`.
  - When `loop_done`=1, go to `WB_PRESENT`. If a word is popped in the same cycle, `rd_r` takes that word.
  - If `loop_done` arrives with no word ever popped, `rd_r`=0.
- `WB_PRESENT`: `done`=1, `id`=`id_r`, `rd`=`rd_r`.
  - When `ack`=1, `wb_committing`=1 for that cycle and the FSM goes to `WB_IDLE`.
  - `res_pop`=0 throughout `WB_PRESENT`.
- `clear_fifos`: only meaningful when the ID FIFO is empty (FSM in `WB_IDLE`). In `WB_IDLE` it causes no state change and pops no words.
  - If it is seen in `WB_COLLECT` or `WB_PRESENT`, it is a protocol error. Flag it with an assertion; the FSM ignores it.
- `res_valid` while in `WB_IDLE`: the word is left in the grid FIFO and is not popped.
- `rd_r` is cleared to 0 on entry to `WB_COLLECT`.

## Timing
- Reset values: state `WB_IDLE`, `done`=0, `wb_committing`=0, `res_pop`=0, `id`=0, `rd`=0, `id_r`/`fb_r`/`rd_r`=0.
- `done`, `id` and `rd` are registered. `res_pop` and `wb_committing` are combinational from state and inputs.
- Non-feedback latency: from `fifo_populated` rising with `res_valid` already 1 to `done`=1 is 2 cycles (IDLE→COLLECT, COLLECT→PRESENT).
- `ack` held 1 gives `done` high for exactly 1 cycle.
- Back-to-back completions:
  - The ID FIFO pop is visible on the cycle after `wb_committing`. `WB_IDLE` therefore samples the new head one cycle after the handshake.
  - Minimum spacing between completions is 3 cycles.
- The ID latch happens only in `WB_IDLE`. This guarantees `wb_id` is never sampled in the cycle the pop takes effect.
- Reset asserted mid-operation returns the FSM to `WB_IDLE` next edge with all outputs at reset values. A pending completion is lost; the controller is reset in the same cycle.

## Structure
- `rca_wb_state_t` enum goes in `rca_config`. `id_t` and `XLEN` come from the existing taiga packages.
- No sub-module: a single FSM plus capture registers.
- Include assertions for:
  - `done` stable until `ack`.
  - `wb_committing` implies `done`.
  - no `clear_fifos` outside `WB_IDLE`.

## Test plan
- Non-feedback single instruction:
  - Stimulus: `fifo_populated`=1, `wb_id`=5, `wb_fb_instr`=0; `res_valid`=1, `res_data`=0xDEADBEEF; `ack`=1.
  - Response: `done`=1 two cycles later with `id`=5, `rd`=0xDEADBEEF; `wb_committing` pulses once; one `res_pop`.
- Feedback instruction:
  - Stimulus: `wb_id`=2, `wb_fb_instr`=1; words 1, 2, 3 arrive on consecutive cycles; `loop_done` asserted with word 3.
  - Response: 3 pops, then `done` with `rd`=3, `id`=2.
- Feedback with no results:
  - Stimulus: `loop_done` arrives with `res_valid`=0 throughout.
  - Response: `rd`=0.
- Backpressure:
  - Stimulus: `ack` held 0 for 10 cycles, then 1.
  - Response: `done`, `id` and `rd` stable all 11 cycles; `res_pop`=0; a single `wb_committing`.
- Back-to-back:
  - Stimulus: IDs 7 then 8 queued; results 0xA, 0xB; `ack`=1.
  - Response: completions in order (7,0xA) then (8,0xB), 3 cycles apart.
- Reset mid-operation:
  - Stimulus: `rst` asserted in `WB_PRESENT`.
  - Response: next cycle `done`=0, `wb_committing`=0, state `WB_IDLE`.
